// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/funct constants, ALU op encodings and skid-buffer state
package alu_pkg;

    // Primary opcode field values
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    // 3-bit operation code handed to the ALU stage
    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_AND     = 3'b001,
        ALU_OR      = 3'b010,
        ALU_SUB     = 3'b011,
        ALU_MUL     = 3'b100,
        ALU_SLT     = 3'b101,
        ALU_ILLEGAL = 3'b111
    } alu_op_e;

    // Occupancy of the 2-entry output skid buffer
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational decode, immediate extension and writeback forwarding
//
// Ports:
//   opcode, funct               instruction fields
//   rs_addr, rt_addr, rd_addr   register indices
//   rs_data, rt_data, imm       register read data and 16-bit immediate
//   wb_en, wb_addr, wb_data     writeback forwarding path
//   a, b, op, dst, illegal      decoded ALU operand bundle (illegal => op=111, a=b=dst=0)
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [2:0]        op,
    output logic [4:0]        dst,
    output logic              illegal
);

    logic              fwd_rs;
    logic              fwd_rt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    alu_op_e           op_e;

    // Register 0 reads as zero and is never a forwarding target, so the
    // zero-index check wins over any writeback match.
    assign fwd_rs = wb_en && (wb_addr != 5'd0) && (wb_addr == rs_addr);
    assign fwd_rt = wb_en && (wb_addr != 5'd0) && (wb_addr == rt_addr);

    assign rs_val = (rs_addr == 5'd0) ? '0 : (fwd_rs ? wb_data : rs_data);
    assign rt_val = (rt_addr == 5'd0) ? '0 : (fwd_rt ? wb_data : rt_data);

    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

    always_comb begin
        a       = '0;
        b       = '0;
        dst     = 5'd0;
        op_e    = ALU_ILLEGAL;
        illegal = 1'b1;

        if (opcode == OPC_RTYPE) begin
            illegal = 1'b0;
            case (funct)
                FUNCT_ADD:  op_e = ALU_ADD;
                FUNCT_AND:  op_e = ALU_AND;
                FUNCT_OR:   op_e = ALU_OR;
                FUNCT_SUB:  op_e = ALU_SUB;
                FUNCT_MULT: op_e = ALU_MUL;
                FUNCT_SLT:  op_e = ALU_SLT;
                default:    illegal = 1'b1;
            endcase
            if (!illegal) begin
                a   = rs_val;
                b   = rt_val;
                dst = rd_addr;
            end
        end else begin
            // I-type: B comes from the immediate, so rt is the destination
            // and is never forwarded.
            illegal = 1'b0;
            case (opcode)
                OPC_ADDI: begin op_e = ALU_ADD; b = imm_sext; end
                OPC_ANDI: begin op_e = ALU_AND; b = imm_zext; end
                OPC_ORI:  begin op_e = ALU_OR;  b = imm_zext; end
                OPC_SLTI: begin op_e = ALU_SLT; b = imm_sext; end
                default:  illegal = 1'b1;
            endcase
            if (!illegal) begin
                a   = rs_val;
                dst = rt_addr;
            end
        end
    end

    assign op = op_e;

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - decode-to-ALU dispatch stage with 2-entry skid buffer
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   in_valid, in_ready          handshake from decode stage
//   opcode, funct, rs/rt/rd_addr, rs_data, rt_data, imm   decoded instruction
//   wb_en, wb_addr, wb_data     writeback forwarding path
//   A, B, op, dst, illegal      operand bundle of the oldest buffered entry
//   out_valid, out_ready        handshake toward the ALU stage
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        op,
    output logic [4:0]        dst,
    output logic              illegal,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ENT_W = 2*DATA_W + 3 + 5 + 1;

    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [2:0]        dec_op;
    logic [4:0]        dec_dst;
    logic              dec_illegal;
    logic [ENT_W-1:0]  dec_ent;

    logic [ENT_W-1:0]  head_q;
    logic [ENT_W-1:0]  tail_q;

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic              push;
    logic              pop;
    logic              load_head;
    logic              load_tail;
    logic              shift;

    alu_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .imm     (imm),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .a       (dec_a),
        .b       (dec_b),
        .op      (dec_op),
        .dst     (dec_dst),
        .illegal (dec_illegal)
    );

    assign dec_ent = {dec_a, dec_b, dec_op, dec_dst, dec_illegal};

    // in_ready is held low while reset is asserted so upstream cannot
    // believe a bundle was taken by a buffer that is being cleared.
    assign in_ready  = RST_N && (state_q != SKID_TWO);
    assign out_valid = (state_q != SKID_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    state_d   = SKID_ONE;
                    load_head = 1'b1;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    // Head leaves and the new bundle takes its place in
                    // the same cycle: no bubble on the output.
                    load_head = 1'b1;
                end else if (push) begin
                    state_d   = SKID_TWO;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_d   = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so only a pop can occur.
                if (pop) begin
                    state_d = SKID_ONE;
                    shift   = 1'b1;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head) begin
                head_q <= dec_ent;
            end else if (shift) begin
                head_q <= tail_q;
            end
            if (load_tail) begin
                tail_q <= dec_ent;
            end
        end
    end

    assign {A, B, op, dst, illegal} = head_q;

endmodule
